// File: rtl/vector_square_iter_if.sv
// Handshake bundle for vector_square_iter: operand vector in, square vector out.
// Carries the per-lane ovf flags only when VECTOR_SQUARE_OVF_EN is defined.
interface vector_square_iter_if #(
  parameter int WIDTH = 24,
  parameter int LANES = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*WIDTH-1:0]     in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*2*WIDTH-1:0]   out_data;
`ifdef VECTOR_SQUARE_OVF_EN
  logic [LANES-1:0]           ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/vector_square_iter.sv
// Multi-lane bit-serial squarer: one multiplier bit per clock, all lanes in lockstep.
// Optional per-lane overflow flags (square wider than WIDTH bits) under VECTOR_SQUARE_OVF_EN.
module vector_square_iter #(
  parameter int WIDTH  = 24,
  parameter int LANES  = 2,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_square_iter_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic            in_ready_int;
  logic            out_valid_int;
  logic            accept;
  logic            last_bit;
  logic            busy_step;
  logic            finish;
  logic            release_out;
  logic [LANES*PW-1:0] out_flat;

  assign last_bit    = (cnt_reg == CW'(WIDTH - 1));
  assign accept      = in_ready_int && bus.in_valid;
  assign busy_step   = (state_reg == BUSY);
  assign finish      = busy_step && last_bit;
  assign release_out = (state_reg == DONE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)       state_next = BUSY;
      BUSY:    if (last_bit)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held, even though state is IDLE.
  always_comb begin
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    case (state_reg)
      IDLE:    in_ready_int  = rst_n;
      DONE:    out_valid_int = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = out_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (accept || finish) begin
      cnt_reg <= '0;
    end else if (busy_step) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

`ifdef VECTOR_SQUARE_OVF_EN
  logic [LANES-1:0] ovf_flat;
  assign bus.ovf = ovf_flat;
`endif

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] operand;
      logic [WIDTH-1:0] mag_in;
      logic [WIDTH-1:0] mag_reg;
      logic [PW-1:0]    acc_reg;
      logic [PW-1:0]    res_reg;
      logic [PW-1:0]    addend;
      logic [PW-1:0]    acc_sum;

      assign operand = bus.in_data[gi*WIDTH +: WIDTH];
      // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
      assign mag_in  = ((SIGNED != 0) && operand[WIDTH-1]) ? (~operand + 1'b1) : operand;
      assign addend  = mag_reg[cnt_reg] ? ({{WIDTH{1'b0}}, mag_reg} << cnt_reg) : '0;
      assign acc_sum = acc_reg + addend;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mag_reg <= '0;
          acc_reg <= '0;
        end else if (accept) begin
          mag_reg <= mag_in;
          acc_reg <= '0;
        end else if (busy_step) begin
          acc_reg <= last_bit ? '0 : acc_sum;
        end
      end

      // The final partial product is folded in on the same edge that enters DONE.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg <= '0;
        end else if (finish) begin
          res_reg <= acc_sum;
        end else if (release_out) begin
          res_reg <= '0;
        end
      end

      assign out_flat[gi*PW +: PW] = res_reg;

`ifdef VECTOR_SQUARE_OVF_EN
      logic ovf_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (finish) begin
          ovf_reg <= |acc_sum[PW-1:WIDTH];
        end else if (release_out) begin
          ovf_reg <= 1'b0;
        end
      end

      assign ovf_flat[gi] = ovf_reg;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_vector_square_iter.sv
// Directed bench: a signed and an unsigned instance driven in lockstep with hand-computed squares.
// Overflow flags are checked when VECTOR_SQUARE_OVF_EN is defined.
module tb_vector_square_iter;
  localparam int W  = 24;
  localparam int L  = 2;
  localparam int PW = 2 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_square_iter_if #(.WIDTH(W), .LANES(L)) bs ();
  vector_square_iter_if #(.WIDTH(W), .LANES(L)) bu ();

  vector_square_iter #(.WIDTH(W), .LANES(L), .SIGNED(1)) u_sgn (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs)
  );

  vector_square_iter #(.WIDTH(W), .LANES(L), .SIGNED(0)) u_uns (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bu)
  );

  int checks   = 0;
  int failures = 0;

  // Operand vectors {lane1, lane0}
  localparam logic [2*W-1:0] D_CASE1 = {24'hFFFFFB, 24'h000003};
  localparam logic [2*W-1:0] D_CASE2 = {24'h000000, 24'h800000};
  localparam logic [2*W-1:0] D_CASE3 = {24'h000001, 24'hFFFFFF};
  localparam logic [2*W-1:0] D_OVF   = {24'h000FFF, 24'h001000};

  // Expected squares {lane1, lane0}
  localparam logic [2*PW-1:0] S_CASE1 = {48'h000000000019, 48'h000000000009};
  localparam logic [2*PW-1:0] U_CASE1 = {48'hFFFFF6000019, 48'h000000000009};
  localparam logic [2*PW-1:0] S_CASE2 = {48'h000000000000, 48'h400000000000};
  localparam logic [2*PW-1:0] U_CASE2 = {48'h000000000000, 48'h400000000000};
  localparam logic [2*PW-1:0] S_CASE3 = {48'h000000000001, 48'h000000000001};
  localparam logic [2*PW-1:0] U_CASE3 = {48'h000000000001, 48'hFFFFFE000001};
  localparam logic [2*PW-1:0] X_OVF   = {48'h000000FFE001, 48'h000001000000};

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2*W-1:0] d);
    bs.in_valid = v;
    bu.in_valid = v;
    bs.in_data  = d;
    bu.in_data  = d;
  endtask

  task automatic set_ready(input logic r);
    bs.out_ready = r;
    bu.out_ready = r;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},  96'({bs.in_ready, bu.in_ready}),   96'(2'b11));
    chk({tag, "_out_valid"}, 96'({bs.out_valid, bu.out_valid}), 96'(2'b00));
    chk({tag, "_data_s"},    96'(bs.out_data), 96'(0));
    chk({tag, "_data_u"},    96'(bu.out_data), 96'(0));
  endtask

  task automatic check_result(input string tag, input logic [2*PW-1:0] s_exp,
                              input logic [2*PW-1:0] u_exp, input logic [1:0] ovf_s,
                              input logic [1:0] ovf_u);
    chk({tag, "_out_valid"}, 96'({bs.out_valid, bu.out_valid}), 96'(2'b11));
    chk({tag, "_in_ready"},  96'({bs.in_ready, bu.in_ready}),   96'(2'b00));
    chk({tag, "_data_s"},    96'(bs.out_data), 96'(s_exp));
    chk({tag, "_data_u"},    96'(bu.out_data), 96'(u_exp));
`ifdef VECTOR_SQUARE_OVF_EN
    chk({tag, "_ovf"}, 96'({bs.ovf, bu.ovf}), 96'({ovf_s, ovf_u}));
`endif
  endtask

  // Called just after the accepting edge; in_data is scrambled to show it is not re-sampled.
  task automatic finish_vec(input string tag, input logic [2*W-1:0] d,
                            input logic [2*PW-1:0] s_exp, input logic [2*PW-1:0] u_exp,
                            input logic [1:0] ovf_s, input logic [1:0] ovf_u);
    drive(1'b0, ~d);
    chk({tag, "_busy_ready"}, 96'({bs.in_ready, bu.in_ready}), 96'(2'b00));
    for (int k = 1; k < W; k++) step();
    chk({tag, "_early_valid"}, 96'({bs.out_valid, bu.out_valid}), 96'(2'b00));
    step();
    check_result(tag, s_exp, u_exp, ovf_s, ovf_u);
  endtask

  task automatic run_vec(input string tag, input logic [2*W-1:0] d,
                         input logic [2*PW-1:0] s_exp, input logic [2*PW-1:0] u_exp,
                         input logic [1:0] ovf_s, input logic [1:0] ovf_u);
    chk({tag, "_pre_ready"}, 96'({bs.in_ready, bu.in_ready}), 96'(2'b11));
    drive(1'b1, d);
    step();
    finish_vec(tag, d, s_exp, u_exp, ovf_s, ovf_u);
  endtask

  initial begin
    logic seen;
    drive(1'b0, '0);
    set_ready(1'b1);
    #2;
    chk("rst_in_ready",  96'({bs.in_ready, bu.in_ready}),   96'(2'b00));
    chk("rst_out_valid", 96'({bs.out_valid, bu.out_valid}), 96'(2'b00));
    chk("rst_data",      96'({bs.out_data, bu.out_data}),   96'(0));
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 96'({bs.in_ready, bu.in_ready}), 96'(2'b11));

    run_vec("case1", D_CASE1, S_CASE1, U_CASE1, 2'b00, 2'b10);
    step();
    check_idle("case1_idle");

    run_vec("case2", D_CASE2, S_CASE2, U_CASE2, 2'b01, 2'b01);
    step();
    check_idle("case2_idle");

    run_vec("ovf", D_OVF, X_OVF, X_OVF, 2'b01, 2'b01);
    step();
    check_idle("ovf_idle");

    // Backpressure: a new vector is offered while the result is stalled.
    set_ready(1'b0);
    run_vec("case3", D_CASE3, S_CASE3, U_CASE3, 2'b00, 2'b01);
    drive(1'b1, D_CASE1);
    for (int k = 0; k < 10; k++) begin
      step();
      check_result($sformatf("bp_hold%0d", k), S_CASE3, U_CASE3, 2'b00, 2'b01);
    end
    set_ready(1'b1);
    step();
    check_idle("bp_release");
    step();
    finish_vec("bp_next", D_CASE1, S_CASE1, U_CASE1, 2'b00, 2'b10);
    step();
    check_idle("bp_next_idle");

    // Reset 10 edges into BUSY discards the vector.
    drive(1'b1, D_CASE2);
    step();
    drive(1'b0, '0);
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst_ready", 96'({bs.in_ready, bu.in_ready}),   96'(2'b00));
    chk("mid_busy_rst_valid", 96'({bs.out_valid, bu.out_valid}), 96'(2'b00));
    chk("mid_busy_rst_data",  96'({bs.out_data, bu.out_data}),   96'(0));
    step();
    step();
    rst_n = 1'b1;
    #1;
    seen = 1'b0;
    for (int k = 0; k < W + 5; k++) begin
      step();
      seen = seen | bs.out_valid | bu.out_valid;
    end
    chk("no_ghost_result", 96'(seen), 96'(0));
    run_vec("fresh", D_CASE1, S_CASE1, U_CASE1, 2'b00, 2'b10);
    step();
    check_idle("fresh_idle");

    // Reset while DONE is stalled drops the result at once.
    set_ready(1'b0);
    run_vec("stall", D_CASE2, S_CASE2, U_CASE2, 2'b01, 2'b01);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_done_rst_valid", 96'({bs.out_valid, bu.out_valid}), 96'(2'b00));
    chk("mid_done_rst_data",  96'({bs.out_data, bu.out_data}),   96'(0));
    step();
    rst_n = 1'b1;
    set_ready(1'b1);
    #1;
    for (int k = 0; k < 3; k++) step();
    check_idle("after_done_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_square_iter.md
Name: vector_square_iter

Overview:
- Multi-lane iterative squarer for the vector machine datapath; parametrised successor to the fixed two-lane, 24-bit combinational squarer.
- Accepts one vector of LANES operands through a valid/ready handshake.
- Squares all lanes in parallel with a bit-serial shift-add engine (one multiplier bit per clock), then returns full-precision results through a second valid/ready handshake.
- Sits between the vector register read port and the writeback stage.

Parameters:
- WIDTH, 24, operand width per lane in bits (>=2).
- LANES, 2, number of parallel lanes (>=1).
- SIGNED, 1, 1 = operands are two's complement; 0 = operands are unsigned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  LANES*WIDTH  operands; lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LANES*2*WIDTH  squares; lane i occupies bits [i*2*WIDTH +: 2*WIDTH].

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: state=IDLE, in_ready=0, out_valid=0, out_data=0, bit counter=0, accumulators=0.
- After reset releases, in_ready=1 from the first cycle.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Accept when in_valid&&in_ready at a rising edge. On accept, per lane latch mag = |operand| as a WIDTH-bit unsigned (SIGNED=1) or the raw operand (SIGNED=0); clear the accumulator and counter; go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each edge: if multiplier bit[counter] of mag=1, add (mag<<counter) to the 2*WIDTH accumulator; counter++. After the edge processing counter=WIDTH-1, go to DONE and load out_data from the accumulators.
  - DONE: out_valid=1, out_data stable. When out_ready=1 at an edge, go to IDLE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: at most one vector per WIDTH+2 cycles. There is no overlap: in_ready stays 0 in BUSY and DONE.
- Input stability: in_data and in_valid are sampled only at the accepting edge; changes while BUSY or DONE are ignored.
- Backpressure: DONE holds indefinitely with out_data unchanged while out_ready=0.
- Arithmetic:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); this fits in WIDTH unsigned bits.
  - Square is never negative. Maximum results fit in 2*WIDTH bits: 2^(2*WIDTH-2) signed, (2^WIDTH-1)^2 unsigned. No truncation.
- out_data is zero-cleared on leaving DONE; it reads 0 in IDLE and BUSY.
- Reset asserted mid-BUSY or mid-DONE: the in-flight vector is discarded immediately, with no output pulse. Accumulators and counter are cleared.
- Lane independence: all lanes share the FSM and counter; a zero operand in one lane does not shorten latency.

Optional Feature:
- Macro: VECTOR_SQUARE_OVF_EN.
- Defined:
  - Adds output port ovf (LANES bits). Bit i is loaded with out_data and is set when the lane-i square exceeds 2^WIDTH-1, i.e. it does not fit a legacy WIDTH-bit consumer.
  - ovf is valid only while out_valid=1; it is 0 otherwise and 0 at reset.
- Not defined: the port is absent and no overflow logic exists.

Test Plan:
- WIDTH=24, LANES=2, SIGNED=1. in_data lane0=24'h000003, lane1=24'hFFFFFB, in_valid for one cycle, out_ready=1 -> out_valid rises 24 edges after accept. Lane0=48'h000000000009, lane1=48'h000000000019. in_ready returns 1 on the next cycle.
- SIGNED=1, lane0=24'h800000, lane1=24'h000000 -> lane0=48'h400000000000, lane1=48'h0.
- SIGNED=0, lane0=24'hFFFFFF, lane1=24'h000001 -> lane0=48'hFFFFFE000001, lane1=48'h000000000001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, driving a new in_valid with different in_data -> out_valid and out_data stay constant and in_ready=0 throughout. The new vector is accepted only after out_ready=1 and a return to IDLE.
- Drop rst_n for 2 cycles 10 edges after accept -> in_ready=0, out_valid=0 and out_data=0 immediately. No result appears afterwards. A fresh vector after release completes normally in 24 edges.
- VECTOR_SQUARE_OVF_EN, SIGNED=0: lane0=24'h001000, lane1=24'h000FFF -> lane0=48'h000001000000 with ovf[0]=1; lane1=48'h000000FFE001 with ovf[1]=0.
